fighter_controller: RTL
=======================

Name: fighter_controller

Overview:
- Per-player character state machine; produces the position and attack-state signals that the character sprite renderer consumes.
- Takes raw player buttons and a per-frame tick from the VGA timing chain.
- Advances movement and attack timing (startup/active/recovery frames) once per video frame.
- Drives x_pos, y_pos, state, attacking and hitbox_active. Opponent hit detection feeds back through got_hit.

Parameters:
- X_INIT, 64: x_pos after reset.
- Y_POS, 240: constant y_pos (64x240 body sits on the bottom of a 480-line screen).
- X_MIN, 0: leftmost legal x_pos.
- X_MAX, 576: rightmost legal x_pos (640-64).
- FWD_SPEED, 3: pixels per frame moving right (forward).
- BACK_SPEED, 2: pixels per frame moving left (back).
- STARTUP_FR, 5: frames in attack startup.
- ACTIVE_FR, 2: frames with live hitbox.
- RECOVERY_FR, 16: frames in attack recovery.
- HITSTUN_FR, 10: frames frozen after being hit.

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  asynchronous active-high reset
- frame_tick  in  1  one-clk pulse per frame (end of active video)
- btn_left  in  1  raw asynchronous button, active-high
- btn_right  in  1  raw asynchronous button, active-high
- btn_attack  in  1  raw asynchronous button, active-high
- got_hit  in  1  one-clk pulse from hit detection, synchronous to clk
- x_pos  out  10  sprite top-left X
- y_pos  out  10  sprite top-left Y
- state  out  3  state encoding below
- attacking  out  1  high in states 4..6
- hitbox_active  out  1  high only in state 5
- attack_frame  out  5  frames elapsed in current timed state

Behaviour:
- Reset: clk and rst only; rst is asynchronous, active-high. On reset: state=IDLE, x_pos=X_INIT, y_pos=Y_POS, attack_frame=0, attacking=0, hitbox_active=0; all sync flops and pending flags cleared. Reset mid-attack aborts immediately.
- Button conditioning: each button passes through a 2-flop synchronizer. A rising edge of synced btn_attack sets attack_pending. A got_hit pulse sets hit_pending. Both flags are cleared on the frame_tick that consumes them.
- Timing: state, x_pos and attack_frame change only on the clk where frame_tick=1. Outputs are registered and valid the clk after that frame_tick. Between ticks, outputs hold.
- State encoding: 0 IDLE, 1 WALK_BACK, 2 WALK_FWD, 3 HITSTUN, 4 ATK_STARTUP, 5 ATK_ACTIVE, 6 ATK_RECOVERY. 7 is illegal and recovers to IDLE at the next tick.
- Priority per tick: hit_pending > attack_pending > movement.
- hit_pending in any state: go to HITSTUN, attack_frame=0. This includes mid-attack, which is cancelled, and HITSTUN itself, where the counter restarts.
- attack_pending from IDLE/WALK_*: go to ATK_STARTUP, attack_frame=0. From states 3..6 the pending attack is discarded (no input buffering).
- Movement from IDLE/WALK_*:
  - left only: WALK_BACK, x_pos -= BACK_SPEED.
  - right only: WALK_FWD, x_pos += FWD_SPEED.
  - both or neither: IDLE, no change.
- Clamp: x_pos saturates to [X_MIN, X_MAX]. Compute in 11 bits and never wrap. Example: x=1 moving back gives 0; x=575 moving forward gives 576.
- Timed states: attack_frame increments each tick. On the tick where attack_frame==N-1 (N = the state's frame parameter), advance and reset attack_frame=0:
  - ATK_STARTUP goes to ATK_ACTIVE.
  - ATK_ACTIVE goes to ATK_RECOVERY.
  - ATK_RECOVERY goes to IDLE.
  - HITSTUN goes to IDLE.
- No movement in states 3..6. attack_frame is 0 in IDLE/WALK.
- Attack total = STARTUP_FR+ACTIVE_FR+RECOVERY_FR ticks (23 by default) from entry to IDLE.
- Simultaneous got_hit and frame_tick on the same clk: the hit is honoured on that tick.

Decomposition:
- Shared package fighter_pkg: state encodings, default frame counts and speeds, and screen limits (640, 480, sprite 64x240). Shared by this block and the renderer.
- One sub-module, btn_conditioner: 2-flop sync plus rising-edge detect, instantiated per button.

Test Plan:
- Reset at x=300 mid-ATK_ACTIVE: outputs go to state=0, x=64, attacking=0 within the same clk, with no wait for a frame tick.
- btn_right held 10 ticks from x=64: x_pos=94, state=2. Then both buttons held: state=0, x held at 94.
- btn_attack pulse in IDLE: state sequence 4 (5 ticks), 5 (2 ticks, hitbox_active=1), 6 (16 ticks), then 0. attacking=1 for exactly 23 ticks.
- got_hit during ATK_STARTUP frame 3: next tick state=3, attacking=0, then 10 ticks later state=0. A second attack press during HITSTUN is ignored.
- btn_left held from x=3: x goes 1 then 0 and stays 0. btn_right held from x=574: x goes 576 and stays 576.
- got_hit and frame_tick asserted on the same clk while walking: state=3 on that tick and x unchanged.

Source files
------------

// File: rtl/fighter_pkg.sv
// Shared fighter definitions: state encoding, default frame timings/speeds and
// screen geometry used by both the controller and the sprite renderer.
package fighter_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SPRITE_W = 64;
  localparam int SPRITE_H = 240;

  localparam int X_INIT_DEF      = 64;
  localparam int Y_POS_DEF       = SCREEN_H - SPRITE_H;
  localparam int X_MIN_DEF       = 0;
  localparam int X_MAX_DEF       = SCREEN_W - SPRITE_W;
  localparam int FWD_SPEED_DEF   = 3;
  localparam int BACK_SPEED_DEF  = 2;
  localparam int STARTUP_FR_DEF  = 5;
  localparam int ACTIVE_FR_DEF   = 2;
  localparam int RECOVERY_FR_DEF = 16;
  localparam int HITSTUN_FR_DEF  = 10;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WALK_BACK    = 3'd1,
    ST_WALK_FWD     = 3'd2,
    ST_HITSTUN      = 3'd3,
    ST_ATK_STARTUP  = 3'd4,
    ST_ATK_ACTIVE   = 3'd5,
    ST_ATK_RECOVERY = 3'd6
  } fstate_e;

  function automatic logic is_attack(fstate_e s);
    return (s == ST_ATK_STARTUP) || (s == ST_ATK_ACTIVE) || (s == ST_ATK_RECOVERY);
  endfunction

endpackage

// File: rtl/fighter_controller_btn_conditioner.sv
// Two-flop synchronizer for a raw button plus a one-clk rising-edge pulse
// taken on the synchronized side.
module btn_conditioner (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/fighter_controller.sv
// Per-player fighter state machine: movement, attack phases and hitstun,
// advanced once per video frame; drives sprite position and attack flags.
module fighter_controller
  import fighter_pkg::*;
#(
  parameter int X_INIT      = X_INIT_DEF,
  parameter int Y_POS       = Y_POS_DEF,
  parameter int X_MIN       = X_MIN_DEF,
  parameter int X_MAX       = X_MAX_DEF,
  parameter int FWD_SPEED   = FWD_SPEED_DEF,
  parameter int BACK_SPEED  = BACK_SPEED_DEF,
  parameter int STARTUP_FR  = STARTUP_FR_DEF,
  parameter int ACTIVE_FR   = ACTIVE_FR_DEF,
  parameter int RECOVERY_FR = RECOVERY_FR_DEF,
  parameter int HITSTUN_FR  = HITSTUN_FR_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_attack,
  input  logic       got_hit,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic [2:0] state,
  output logic       attacking,
  output logic       hitbox_active,
  output logic [4:0] attack_frame
);

  logic left_lvl, right_lvl, atk_lvl;
  logic left_rise, right_rise, atk_rise;
  logic unused_cond;

  btn_conditioner u_left  (.clk(clk), .rst(rst), .btn_i(btn_left),   .level_o(left_lvl),  .rise_o(left_rise));
  btn_conditioner u_right (.clk(clk), .rst(rst), .btn_i(btn_right),  .level_o(right_lvl), .rise_o(right_rise));
  btn_conditioner u_atk   (.clk(clk), .rst(rst), .btn_i(btn_attack), .level_o(atk_lvl),   .rise_o(atk_rise));

  // Movement acts on held levels; only the attack press is edge-triggered.
  assign unused_cond = left_rise ^ right_rise ^ atk_lvl;

  fstate_e    state_q, state_d;
  logic [9:0] x_q, x_d;
  logic [4:0] frame_q, frame_d;
  logic       hit_pend_q, hit_pend_d, atk_pend_q, atk_pend_d;
  logic       attacking_q, attacking_d, hitbox_q, hitbox_d;
  logic       hit_now, atk_now;

  function automatic logic [9:0] step_back(input logic [9:0] x);
    logic [10:0] xe;
    xe = {1'b0, x};
    if (xe < 11'(X_MIN + BACK_SPEED)) return 10'(X_MIN);
    return 10'(xe - 11'(BACK_SPEED));
  endfunction

  function automatic logic [9:0] step_fwd(input logic [9:0] x);
    logic [10:0] sum;
    sum = {1'b0, x} + 11'(FWD_SPEED);
    if (sum > 11'(X_MAX)) return 10'(X_MAX);
    return sum[9:0];
  endfunction

  // A hit or press landing on the tick clock itself is honoured on that tick.
  assign hit_now = hit_pend_q | got_hit;
  assign atk_now = atk_pend_q | atk_rise;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    frame_d    = frame_q;
    hit_pend_d = hit_now;
    atk_pend_d = atk_now;
    if (frame_tick) begin
      hit_pend_d = 1'b0;
      atk_pend_d = 1'b0;
      if (hit_now) begin
        state_d = ST_HITSTUN;
        frame_d = 5'd0;
      end else begin
        case (state_q)
          ST_IDLE, ST_WALK_BACK, ST_WALK_FWD: begin
            frame_d = 5'd0;
            if (atk_now) begin
              state_d = ST_ATK_STARTUP;
            end else if (left_lvl && !right_lvl) begin
              state_d = ST_WALK_BACK;
              x_d     = step_back(x_q);
            end else if (right_lvl && !left_lvl) begin
              state_d = ST_WALK_FWD;
              x_d     = step_fwd(x_q);
            end else begin
              state_d = ST_IDLE;
            end
          end
          ST_HITSTUN: begin
            frame_d = frame_q + 5'd1;
            if (frame_q == 5'(HITSTUN_FR - 1)) begin
              state_d = ST_IDLE;
              frame_d = 5'd0;
            end
          end
          ST_ATK_STARTUP: begin
            frame_d = frame_q + 5'd1;
            if (frame_q == 5'(STARTUP_FR - 1)) begin
              state_d = ST_ATK_ACTIVE;
              frame_d = 5'd0;
            end
          end
          ST_ATK_ACTIVE: begin
            frame_d = frame_q + 5'd1;
            if (frame_q == 5'(ACTIVE_FR - 1)) begin
              state_d = ST_ATK_RECOVERY;
              frame_d = 5'd0;
            end
          end
          ST_ATK_RECOVERY: begin
            frame_d = frame_q + 5'd1;
            if (frame_q == 5'(RECOVERY_FR - 1)) begin
              state_d = ST_IDLE;
              frame_d = 5'd0;
            end
          end
          default: begin
            state_d = ST_IDLE;
            frame_d = 5'd0;
          end
        endcase
      end
    end
    attacking_d = is_attack(state_d);
    hitbox_d    = (state_d == ST_ATK_ACTIVE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      x_q         <= 10'(X_INIT);
      frame_q     <= 5'd0;
      hit_pend_q  <= 1'b0;
      atk_pend_q  <= 1'b0;
      attacking_q <= 1'b0;
      hitbox_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      frame_q     <= frame_d;
      hit_pend_q  <= hit_pend_d;
      atk_pend_q  <= atk_pend_d;
      attacking_q <= attacking_d;
      hitbox_q    <= hitbox_d;
    end
  end

  assign x_pos         = x_q;
  assign y_pos         = 10'(Y_POS);
  assign state         = state_q;
  assign attacking     = attacking_q;
  assign hitbox_active = hitbox_q;
  assign attack_frame  = frame_q;

endmodule
